// File: rtl/ahb2apb_bridge_p_if.sv
// ahb2apb_bridge_p_if
// Bus bundle between the AHB-Lite master side and the APB4 slave side of the
// bridge. The bridge connects through the 'slave' modport; the bench drives
// the AHB master and the APB slaves through the 'master' modport.
//
// Handshake: the bridge takes an address phase only when Htrans is NON_SEQ or
// SEQ and Hreadyin=1 while it is idle. Hreadyout=0 stretches the data phase;
// Hresp is meaningful in every cycle and reads ERROR for the two-cycle error
// response. On APB a transfer ends in the ACCESS cycle (Pselx && Penable) in
// which Pready=1; Pslverr is only looked at in that cycle.
//
// Signals:
//   AHB : Htrans, Hwrite, Hsize, Hreadyin, Haddr, Hwdata -> bridge
//         Hrdata, Hreadyout, Hresp                       <- bridge
//   APB : Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb   <- bridge
//         Prdata, Pready, Pslverr                        -> bridge
interface ahb2apb_bridge_p_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
) ();
  logic [1:0]          Htrans;
  logic                Hwrite;
  logic [2:0]          Hsize;
  logic                Hreadyin;
  logic [ADDR_W-1:0]   Haddr;
  logic [DATA_W-1:0]   Hwdata;
  logic [DATA_W-1:0]   Hrdata;
  logic                Hreadyout;
  logic [1:0]          Hresp;

  logic [NUM_SLV-1:0]  Pselx;
  logic                Penable;
  logic                Pwrite;
  logic [ADDR_W-1:0]   Paddr;
  logic [DATA_W-1:0]   Pwdata;
  logic [DATA_W/8-1:0] Pstrb;
  logic [DATA_W-1:0]   Prdata;
  logic                Pready;
  logic                Pslverr;

  modport slave (
    input  Htrans, Hwrite, Hsize, Hreadyin, Haddr, Hwdata,
    output Hrdata, Hreadyout, Hresp,
    output Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb,
    input  Prdata, Pready, Pslverr
  );

  modport master (
    output Htrans, Hwrite, Hsize, Hreadyin, Haddr, Hwdata,
    input  Hrdata, Hreadyout, Hresp,
    input  Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/ahb2apb_bridge_p.sv
// ahb2apb_bridge_p
// AHB-Lite slave to APB4 master bridge, one transfer outstanding. NUM_SLV equal
// regions of 2**SPAN_LOG2 bytes starting at BASE_ADDR are decoded into a
// one-hot Pselx. Decode misses, illegal size/alignment, Pslverr and a Pready
// timeout all end in a two-cycle AHB ERROR response.
//
// Ports:
//   clk       : clock, rising edge
//   Hrst      : synchronous active-high reset
//   bus       : ahb2apb_bridge_p_if.slave (AHB side in/out, APB side out/in)
//   dbg_state : current FSM state encoding (IDLE=0 WDATA=1 SETUP=2 ACCESS=3
//               ERR1=4 ERR2=5)
module ahb2apb_bridge_p #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_SLV   = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                SPAN_LOG2 = 24,
  parameter int                TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                Hrst,
  ahb2apb_bridge_p_if.slave   bus,
  output logic [2:0]          dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SZ_MAX = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // One extra bit so the window end cannot wrap at the top of the address map.
  localparam logic [ADDR_W:0] WIN_SIZE = (ADDR_W+1)'(NUM_SLV) << SPAN_LOG2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [TO_W-1:0]    to_cnt, to_cnt_nx;
  logic [IDX_W-1:0]   idx_q, dec_idx, idx_sel;

  logic [DATA_W-1:0]  hrdata_q;
  logic               hreadyout_q, hreadyout_nx;
  logic [1:0]         hresp_q, hresp_nx;
  logic [NUM_SLV-1:0] pselx_q, pselx_nx;
  logic               penable_q, penable_nx;
  logic               pwrite_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic [STRB_W-1:0]  pstrb_q;

  // Address-phase decode (only used while idle)
  logic [ADDR_W-1:0]  offset, amask;
  logic               hit, size_ok, align_ok, legal, xfer_valid;
  logic [STRB_W-1:0]  strb_dec;
  int                 lane, nbytes;

  always_comb begin
    offset     = bus.Haddr - BASE_ADDR;
    dec_idx    = IDX_W'(offset >> SPAN_LOG2);
    hit        = (bus.Haddr >= BASE_ADDR) && ({1'b0, offset} < WIN_SIZE);
    size_ok    = (bus.Hsize <= 3'(SZ_MAX));
    amask      = (ADDR_W'(1) << bus.Hsize) - ADDR_W'(1);
    align_ok   = ((bus.Haddr & amask) == '0);
    legal      = hit && size_ok && align_ok;
    xfer_valid = ((bus.Htrans == 2'b10) || (bus.Htrans == 2'b11)) && bus.Hreadyin;
    // Byte lanes: 2**Hsize ones starting at the low address bits.
    lane       = int'(bus.Haddr[SZ_MAX-1:0]);
    nbytes     = 1 << bus.Hsize;
    strb_dec   = '0;
    for (int b = 0; b < STRB_W; b++) begin
      if ((b >= lane) && (b < lane + nbytes)) strb_dec[b] = 1'b1;
    end
  end

  // Next state and next values of the registered bus outputs
  always_comb begin
    state_nx  = state;
    to_cnt_nx = to_cnt;
    case (state)
      S_IDLE: begin
        if (xfer_valid) begin
          if (!legal)          state_nx = S_ERR1;
          else if (bus.Hwrite) state_nx = S_WDATA;
          else                 state_nx = S_SETUP;
        end
      end
      S_WDATA: state_nx = S_SETUP;
      S_SETUP: begin
        state_nx  = S_ACCESS;
        to_cnt_nx = '0;
      end
      S_ACCESS: begin
        // Pready is checked first so it wins over a same-cycle timeout.
        if (bus.Pready) begin
          state_nx = bus.Pslverr ? S_ERR1 : S_IDLE;
        end else if ((TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1))) begin
          state_nx = S_ERR1;
        end else begin
          to_cnt_nx = to_cnt + 1'b1;
        end
      end
      S_ERR1:  state_nx = S_ERR2;
      S_ERR2:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    hreadyout_nx = (state_nx == S_IDLE) || (state_nx == S_ERR2);
    hresp_nx     = ((state_nx == S_ERR1) || (state_nx == S_ERR2)) ? 2'b01 : 2'b00;
    // The slave index is latched on the same edge that leaves IDLE.
    idx_sel      = (state == S_IDLE) ? dec_idx : idx_q;
    pselx_nx     = ((state_nx == S_SETUP) || (state_nx == S_ACCESS)) ?
                   (NUM_SLV'(1) << idx_sel) : '0;
    penable_nx   = (state_nx == S_ACCESS);
  end

  always_ff @(posedge clk) begin
    if (Hrst) begin
      state  <= S_IDLE;
      to_cnt <= '0;
    end else begin
      state  <= state_nx;
      to_cnt <= to_cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (Hrst) begin
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
      hrdata_q    <= '0;
      pselx_q     <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      idx_q       <= '0;
    end else begin
      hreadyout_q <= hreadyout_nx;
      hresp_q     <= hresp_nx;
      pselx_q     <= pselx_nx;
      penable_q   <= penable_nx;
      if ((state == S_IDLE) && xfer_valid) begin
        paddr_q  <= bus.Haddr;
        pwrite_q <= bus.Hwrite;
        pstrb_q  <= bus.Hwrite ? strb_dec : '0;
        idx_q    <= dec_idx;
      end
      if (state == S_WDATA) pwdata_q <= bus.Hwdata;
      if ((state == S_ACCESS) && bus.Pready && !bus.Pslverr && !pwrite_q)
        hrdata_q <= bus.Prdata;
    end
  end

  assign bus.Hrdata    = hrdata_q;
  assign bus.Hreadyout = hreadyout_q;
  assign bus.Hresp     = hresp_q;
  assign bus.Pselx     = pselx_q;
  assign bus.Penable   = penable_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.Pstrb     = pstrb_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_ahb2apb_bridge_p.sv
// tb_ahb2apb_bridge_p
// Directed bench for ahb2apb_bridge_p (default parameters, TIMEOUT=16):
// a vector table of single transfers plus hand-written sequences for reset in
// ACCESS, ignored transfers, ERR2 not sampling, and an INCR4 write burst.
module tb_ahb2apb_bridge_p;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_SLV = 4;
  localparam int W       = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic Hrst;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  ahb2apb_bridge_p_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV)) bus ();

  ahb2apb_bridge_p #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV),
    .BASE_ADDR(32'h8000_0000), .SPAN_LOG2(24), .TIMEOUT(16)
  ) dut (
    .clk(clk), .Hrst(Hrst), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int viol  = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // APB protocol watch: Pselx one-hot-or-zero, Penable only with Pselx.
  always @(negedge clk) begin
    if (!Hrst) begin
      if (!$onehot0(bus.Pselx)) viol++;
      if (bus.Penable && (bus.Pselx == '0)) viol++;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        slverr;
    int          waits;   // ACCESS cycles with Pready=0 before Pready=1
    logic        err;
    logic [3:0]  psel;
    logic [3:0]  strb;
    int          low;     // cycles with Hreadyout=0
    int          pen;     // cycles with Penable=1
    logic [31:0] hrdata;  // Hrdata after the transfer
  } vec_t;

  localparam int NV = 16;
  vec_t vt[NV];

  logic [3:0]  obs_psel, obs_strb;
  logic [31:0] obs_paddr, obs_pwdata;
  logic [1:0]  obs_resp_low, obs_resp_end;
  int          obs_low, obs_pen, obs_cyc;

  // ---------------- driver tasks ----------------
  // Called at a negedge with the bridge idle; acts as AHB master and APB slave.
  task automatic run_xfer(input vec_t v);
    int acc;
    acc = 0;
    obs_psel = '0; obs_strb = '0; obs_paddr = '0; obs_pwdata = '0;
    obs_low = 0; obs_pen = 0; obs_resp_low = 2'b00; obs_cyc = 0;
    bus.Htrans = 2'b10; bus.Haddr = v.addr; bus.Hwrite = v.wr;
    bus.Hsize = v.size; bus.Hreadyin = 1'b1;
    bus.Prdata = v.rdata; bus.Pready = 1'b0; bus.Pslverr = 1'b0;
    @(negedge clk);
    bus.Htrans = 2'b00;
    bus.Hwdata = v.wdata;
    while (bus.Hreadyout == 1'b0 && obs_cyc < 100) begin
      obs_low++;
      obs_resp_low = bus.Hresp;
      obs_psel = obs_psel | bus.Pselx;
      if (bus.Penable) begin
        obs_pen++;
        obs_strb   = bus.Pstrb;
        obs_paddr  = bus.Paddr;
        obs_pwdata = bus.Pwdata;
        bus.Pready  = (acc >= v.waits);
        bus.Pslverr = bus.Pready & v.slverr;
        acc++;
      end else begin
        bus.Pready  = 1'b0;
        bus.Pslverr = 1'b0;
      end
      obs_cyc++;
      @(negedge clk);
    end
    bus.Pready = 1'b0;
    bus.Pslverr = 1'b0;
    obs_resp_end = bus.Hresp;
  endtask

  task automatic run_incr4();
    int issued, done, low, rises, cyc;
    logic issue_prev;
    logic [3:0] psel_prev;
    logic [W-1:0] e;
    issued = 0; done = 0; low = 0; rises = 0; cyc = 0;
    issue_prev = 1'b0; psel_prev = '0;
    for (int k = 0; k < 4; k++)
      exp_q.push_back({32'h8300_0000 + 32'(k * 4), 32'hC0DE_0000 + 32'(k)});
    bus.Pready = 1'b1; bus.Pslverr = 1'b0; bus.Hreadyin = 1'b1;
    while (done < 4 && cyc < 200) begin
      if (bus.Pselx != '0 && psel_prev == '0) rises++;
      psel_prev = bus.Pselx;
      if (!bus.Hreadyout) low++;
      if (bus.Penable && bus.Pready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("incr4_beat%0d", done), {bus.Paddr, bus.Pwdata}, e);
        end
        chk($sformatf("incr4_pwrite%0d", done), bus.Pwrite, 1'b1);
        done++;
      end
      // Write data follows its address phase by one cycle.
      if (issue_prev) bus.Hwdata = 32'hC0DE_0000 + 32'(issued - 1);
      issue_prev = 1'b0;
      if (bus.Hreadyout) begin
        if (issued < 4) begin
          bus.Htrans = (issued == 0) ? 2'b10 : 2'b11;
          bus.Haddr  = 32'h8300_0000 + 32'(issued * 4);
          bus.Hwrite = 1'b1;
          bus.Hsize  = 3'd2;
          issued++;
          issue_prev = 1'b1;
        end else begin
          bus.Htrans = 2'b00;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.Htrans = 2'b00;
    bus.Pready = 1'b0;
    chk("incr4_beats_done", 64'(done), 64'd4);
    chk("incr4_cycles", 64'(cyc), 64'd16);
    chk("incr4_hready_low", 64'(low), 64'd12);
    chk("incr4_psel_rises", 64'(rises), 64'd4);
    chk("incr4_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("incr4_end_ready", bus.Hreadyout, 1'b1);
    chk("incr4_end_resp", bus.Hresp, 2'b00);
  endtask

  // ---------------- test ----------------
  initial begin
    //        wr    size  addr           wdata          rdata          slv  wt   err   psel     strb     low pen hrdata
    vt[0]  = '{1'b0, 3'd2, 32'h8200_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0,  1'b0, 4'b0100, 4'b0000, 2,  1,  32'hDEAD_BEEF};
    vt[1]  = '{1'b1, 3'd0, 32'h8100_0002, 32'h00AB_0000, 32'h5555_5555, 1'b0, 3,  1'b0, 4'b0010, 4'b0100, 6,  4,  32'hDEAD_BEEF};
    vt[2]  = '{1'b0, 3'd2, 32'h9000_0000, 32'h0,         32'h1111_1111, 1'b0, 0,  1'b1, 4'b0000, 4'b0000, 1,  0,  32'hDEAD_BEEF};
    vt[3]  = '{1'b0, 3'd1, 32'h8000_0001, 32'h0,         32'h1111_1111, 1'b0, 0,  1'b1, 4'b0000, 4'b0000, 1,  0,  32'hDEAD_BEEF};
    vt[4]  = '{1'b0, 3'd3, 32'h8000_0000, 32'h0,         32'h1111_1111, 1'b0, 0,  1'b1, 4'b0000, 4'b0000, 1,  0,  32'hDEAD_BEEF};
    vt[5]  = '{1'b1, 3'd2, 32'h8000_0004, 32'hA5A5_0F0F, 32'h3333_3333, 1'b1, 0,  1'b1, 4'b0001, 4'b1111, 4,  1,  32'hDEAD_BEEF};
    vt[6]  = '{1'b0, 3'd2, 32'h8300_0000, 32'h0,         32'h2222_2222, 1'b1, 1,  1'b1, 4'b1000, 4'b0000, 4,  2,  32'hDEAD_BEEF};
    vt[7]  = '{1'b0, 3'd2, 32'h8100_0000, 32'h0,         32'h4444_4444, 1'b0, 100,1'b1, 4'b0010, 4'b0000, 18, 16, 32'hDEAD_BEEF};
    vt[8]  = '{1'b1, 3'd1, 32'h8300_0002, 32'h1234_0000, 32'h6666_6666, 1'b0, 0,  1'b0, 4'b1000, 4'b1100, 3,  1,  32'hDEAD_BEEF};
    vt[9]  = '{1'b0, 3'd0, 32'h8000_0003, 32'h0,         32'hCAFE_F00D, 1'b0, 2,  1'b0, 4'b0001, 4'b0000, 4,  3,  32'hCAFE_F00D};
    vt[10] = '{1'b0, 3'd2, 32'h8200_0000, 32'h0,         32'h0BAD_CAFE, 1'b0, 15, 1'b0, 4'b0100, 4'b0000, 17, 16, 32'h0BAD_CAFE};
    vt[11] = '{1'b1, 3'd2, 32'h83FF_FFFC, 32'h0102_0304, 32'h7777_7777, 1'b0, 0,  1'b0, 4'b1000, 4'b1111, 3,  1,  32'h0BAD_CAFE};
    vt[12] = '{1'b0, 3'd2, 32'h7FFF_FFFC, 32'h0,         32'h8888_8888, 1'b0, 0,  1'b1, 4'b0000, 4'b0000, 1,  0,  32'h0BAD_CAFE};
    vt[13] = '{1'b0, 3'd2, 32'h8400_0000, 32'h0,         32'h9999_9999, 1'b0, 0,  1'b1, 4'b0000, 4'b0000, 1,  0,  32'h0BAD_CAFE};
    vt[14] = '{1'b1, 3'd1, 32'h8000_0000, 32'h0000_FFFF, 32'hAAAA_AAAA, 1'b0, 0,  1'b0, 4'b0001, 4'b0011, 3,  1,  32'h0BAD_CAFE};
    vt[15] = '{1'b1, 3'd0, 32'h8200_0001, 32'h0000_7700, 32'hBBBB_BBBB, 1'b0, 1,  1'b0, 4'b0100, 4'b0010, 4,  2,  32'h0BAD_CAFE};

    // reset
    Hrst = 1'b1;
    bus.Htrans = 2'b00; bus.Hwrite = 1'b0; bus.Hsize = 3'd0; bus.Hreadyin = 1'b1;
    bus.Haddr = '0; bus.Hwdata = '0; bus.Prdata = '0; bus.Pready = 1'b0; bus.Pslverr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hreadyout", bus.Hreadyout, 1'b1);
    chk("rst_hresp", bus.Hresp, 2'b00);
    chk("rst_hrdata", bus.Hrdata, 32'h0);
    chk("rst_pselx", bus.Pselx, 4'b0000);
    chk("rst_penable", bus.Penable, 1'b0);
    chk("rst_pwrite", bus.Pwrite, 1'b0);
    chk("rst_paddr", bus.Paddr, 32'h0);
    chk("rst_pwdata", bus.Pwdata, 32'h0);
    chk("rst_pstrb", bus.Pstrb, 4'b0000);
    chk("rst_state", dbg_state, 3'd0);
    Hrst = 1'b0;
    @(negedge clk);

    // table-driven single transfers
    for (int i = 0; i < NV; i++) begin
      run_xfer(vt[i]);
      chk($sformatf("v%0d_hang", i), 64'(obs_cyc < 100), 64'd1);
      chk($sformatf("v%0d_resp_end", i), obs_resp_end, vt[i].err ? 2'b01 : 2'b00);
      chk($sformatf("v%0d_resp_low", i), obs_resp_low, vt[i].err ? 2'b01 : 2'b00);
      chk($sformatf("v%0d_pselx", i), obs_psel, vt[i].psel);
      chk($sformatf("v%0d_pstrb", i), obs_strb, vt[i].strb);
      chk($sformatf("v%0d_hready_low", i), 64'(obs_low), 64'(vt[i].low));
      chk($sformatf("v%0d_penable_cycles", i), 64'(obs_pen), 64'(vt[i].pen));
      chk($sformatf("v%0d_hrdata", i), bus.Hrdata, vt[i].hrdata);
      if (vt[i].pen > 0) chk($sformatf("v%0d_paddr", i), obs_paddr, vt[i].addr);
      if (vt[i].wr && vt[i].pen > 0) chk($sformatf("v%0d_pwdata", i), obs_pwdata, vt[i].wdata);
      // After ERR2 the master cancels; step to the following IDLE cycle.
      if (obs_resp_end != 2'b00) @(negedge clk);
    end

    // Ignored transfers: Hreadyin low, then BUSY
    bus.Htrans = 2'b10; bus.Haddr = 32'h8000_0000; bus.Hwrite = 1'b0; bus.Hsize = 3'd2;
    bus.Hreadyin = 1'b0;
    @(negedge clk);
    chk("ign_hreadyin_state", dbg_state, 3'd0);
    chk("ign_hreadyin_pselx", bus.Pselx, 4'b0000);
    bus.Htrans = 2'b01; bus.Hreadyin = 1'b1;
    @(negedge clk);
    chk("ign_busy_state", dbg_state, 3'd0);
    chk("ign_busy_hresp", bus.Hresp, 2'b00);
    chk("ign_busy_hready", bus.Hreadyout, 1'b1);
    bus.Htrans = 2'b00;

    // ERR2 must not take a new address phase
    bus.Htrans = 2'b10; bus.Haddr = 32'h9000_0000; bus.Hwrite = 1'b0; bus.Hsize = 3'd2;
    @(negedge clk);
    bus.Htrans = 2'b00;
    chk("err1_hready", bus.Hreadyout, 1'b0);
    chk("err1_hresp", bus.Hresp, 2'b01);
    @(negedge clk);
    chk("err2_hready", bus.Hreadyout, 1'b1);
    chk("err2_hresp", bus.Hresp, 2'b01);
    bus.Htrans = 2'b10; bus.Haddr = 32'h8000_0000;
    @(negedge clk);
    bus.Htrans = 2'b00;
    chk("err2_nosample_state", dbg_state, 3'd0);
    chk("err2_nosample_pselx", bus.Pselx, 4'b0000);

    // INCR4 burst of back-to-back writes
    run_incr4();

    // Reset while in ACCESS
    bus.Htrans = 2'b10; bus.Haddr = 32'h8000_0000; bus.Hwrite = 1'b0; bus.Hsize = 3'd2;
    bus.Pready = 1'b0;
    @(negedge clk);
    bus.Htrans = 2'b00;
    chk("rstacc_setup_pselx", bus.Pselx, 4'b0001);
    @(negedge clk);
    chk("rstacc_access_penable", bus.Penable, 1'b1);
    Hrst = 1'b1;
    @(negedge clk);
    chk("rstacc_pselx", bus.Pselx, 4'b0000);
    chk("rstacc_penable", bus.Penable, 1'b0);
    chk("rstacc_hready", bus.Hreadyout, 1'b1);
    chk("rstacc_hresp", bus.Hresp, 2'b00);
    chk("rstacc_hrdata", bus.Hrdata, 32'h0);
    @(negedge clk);
    Hrst = 1'b0;
    @(negedge clk);
    chk("rstacc_state", dbg_state, 3'd0);

    chk("apb_protocol_violations", 64'(viol), 64'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
